dense_mac_layer: RTL and testbench
==================================

Name: dense_mac_layer

Overview:
Time-multiplexed fully connected layer. One signed multiplier-accumulator computes y[j] = bias[j] + sum_i w[j][i]*x[i] for every output neuron in turn. Weights and biases stream from an external synchronous memory. Instantiated twice in the network: once as dense 1 (26->32, 16b in, 24b out) and once as dense 2 (32->3, 24b in, 32b out). Dense 2 feeds the final 2-bit class decision.

Parameters:
IN_SIZE, 26, number of input features
OUT_SIZE, 32, number of output neurons
IN_WIDTH, 16, signed input element width
OUT_WIDTH, 24, signed output element width
WB_WIDTH, 8, signed weight/bias width
ADDR_WIDTH, $clog2(OUT_SIZE*(IN_SIZE+1)), weight-memory address width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  IN_SIZE*IN_WIDTH  input vector, element i at bits [i*IN_WIDTH +: IN_WIDTH]
wb_rd_en  out  1  weight-memory read strobe
wb_addr  out  ADDR_WIDTH  weight-memory address
wb_data  in  WB_WIDTH  read data, valid exactly 1 cycle after wb_rd_en
out_valid  out  1  output vector valid
out_ready  in  1  consumer accepts the vector
out_data  out  OUT_SIZE*OUT_WIDTH  result vector, element j at bits [j*OUT_WIDTH +: OUT_WIDTH]
busy  out  1  computation in progress

Behaviour:
- Reset values: in_ready=1, out_valid=0, busy=0, wb_rd_en=0, wb_addr=0, out_data=0. Internal registers and the FSM are cleared. Reset mid-computation aborts the computation and discards partial results.
- Memory layout: neuron j occupies addresses j*(IN_SIZE+1) .. j*(IN_SIZE+1)+IN_SIZE-1 for weights w[j][0..IN_SIZE-1]. The bias is at j*(IN_SIZE+1)+IN_SIZE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the internal vector register and go to RUN.
  - RUN: wb_rd_en=1 every cycle. wb_addr increments by 1 from 0 to OUT_SIZE*(IN_SIZE+1)-1.
  - DRAIN: one cycle to absorb the last read.
  - DONE: out_valid=1, holds until out_ready.
- Handshake:
  - in_ready=0 in RUN, DRAIN and DONE.
  - out_data is stable while out_valid=1.
  - On out_valid&&out_ready, go to IDLE.
  - A new vector cannot be accepted in the same cycle as the output handshake. in_ready rises the following cycle.
- Datapath: one cycle behind the address (read latency 1).
  - A weight beat does acc += x[i]*w. For i==0, acc = x[0]*w, which clears the previous neuron.
  - A bias beat computes acc + sign-extended bias, saturates it to OUT_WIDTH, and writes it into out_data element j.
  - ACC_WIDTH = IN_WIDTH+WB_WIDTH+$clog2(IN_SIZE+1), which is 29 for the defaults.
  - All arithmetic is signed two's complement. There is no shift or rounding. Saturation clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Latency: with the input handshake in cycle 0, out_valid rises in cycle OUT_SIZE*(IN_SIZE+1)+2. This is 866 for the defaults and 101 for dense 2 (32->3).
- busy=1 exactly in RUN and DRAIN.
- in_valid held high while the block is busy has no effect. in_data changes during RUN are ignored because the input vector is latched.

Optional Feature:
Macro DENSE_RELU_EN.
- Defined: each saturated neuron result passes through ReLU before storage (negative results are stored as 0).
- Undefined: the signed saturated value is stored unchanged.
- Latency is identical in both builds.

Decomposition:
- Package nn_parameters additions:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dense_state_t
  - localparam ACC_WIDTH_1 and ACC_WIDTH_2, for the two layer instances
- Sub-module dense_mac_saturate: a combinational/registered signed multiply-accumulate with an OUT_WIDTH saturator. Contains no control logic.

Test Plan:
- Defaults, x[i]=1 for all i, w=1, bias=0 → every out element = 26; out_valid at cycle 866; 864 reads total, addresses 0..863 in order.
- x[i]=32767, w=127, bias=127 → 26*32767*127+127 exceeds 2^23-1, so every element = 8388607. With all weights -128 and bias -128 → every element = -8388608.
- Dense 2 config (IN 32, OUT 3, IN_WIDTH 24, OUT_WIDTH 32), x[i]=i, w[j][i]=j+1, bias[j]=-10:
  - Without DENSE_RELU_EN → outputs {486, 982, 1478}.
  - With w[0][*]=-1 → output 0 = -506 without the macro and 0 with DENSE_RELU_EN.
- Hold out_ready=0 for 20 cycles after out_valid → out_valid and out_data stay stable and in_ready stays 0. After the handshake, in_ready=1 on the next cycle.
- Assert rst at cycle 400 of a defaults run → next cycle shows in_ready=1, out_valid=0, wb_rd_en=0, busy=0. A fresh vector then completes with the correct result 866 cycles after its handshake.
- Back-to-back vectors: apply the second vector with in_valid held high → it is accepted only in the cycle after the first output handshake, and its result is independent of the first vector.

Source files
------------

// File: rtl/nn_parameters.sv
// Shared state encoding and accumulator widths for the dense MAC layers.
// The DENSE_RELU_EN build option is handled in dense_mac_saturate.
package nn_parameters;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dense_state_t;

    function automatic int acc_width(int in_w, int wb_w, int in_size);
        return in_w + wb_w + $clog2(in_size + 1);
    endfunction

    localparam int ACC_WIDTH_1 = acc_width(16, 8, 26);
    localparam int ACC_WIDTH_2 = acc_width(24, 8, 32);

endpackage

// File: rtl/dense_mac_layer_if.sv
// Vector, weight-memory and result handshake bundle of a dense MAC layer.
// master: producer/memory/consumer side, slave: the layer itself.
interface dense_mac_layer_if #(
    parameter int IN_SIZE    = 26,
    parameter int OUT_SIZE   = 32,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 24,
    parameter int WB_WIDTH   = 8,
    parameter int ADDR_WIDTH = $clog2(OUT_SIZE * (IN_SIZE + 1))
);

    logic                          in_valid;
    logic                          in_ready;
    logic [IN_SIZE*IN_WIDTH-1:0]   in_data;
    logic                          wb_rd_en;
    logic [ADDR_WIDTH-1:0]         wb_addr;
    logic [WB_WIDTH-1:0]           wb_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [OUT_SIZE*OUT_WIDTH-1:0] out_data;
    logic                          busy;

    modport master (
        output in_valid, in_data, wb_data, out_ready,
        input  in_ready, wb_rd_en, wb_addr, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, wb_data, out_ready,
        output in_ready, wb_rd_en, wb_addr, out_valid, out_data, busy
    );

endinterface

// File: rtl/dense_mac_saturate.sv
// Signed multiply-accumulate plus bias add and OUT_WIDTH saturation.
// Build option DENSE_RELU_EN: clamp negative saturated results to zero.
module dense_mac_saturate #(
    parameter int IN_WIDTH  = 16,
    parameter int WB_WIDTH  = 8,
    parameter int ACC_WIDTH = 29,
    parameter int OUT_WIDTH = 24
) (
    input  logic signed [IN_WIDTH-1:0]  x_i,
    input  logic signed [WB_WIDTH-1:0]  wb_i,
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    input  logic                        first_i,
    output logic signed [ACC_WIDTH-1:0] mac_o,
    output logic signed [OUT_WIDTH-1:0] res_o
);

    localparam int PW = IN_WIDTH + WB_WIDTH;
    localparam int SW = ACC_WIDTH + 1;

    localparam logic [OUT_WIDTH-1:0] SMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [SW-1:0]        sum;
    logic [SW-OUT_WIDTH:0]       top;
    logic                        fits;
    logic signed [OUT_WIDTH-1:0] sat;

    assign prod  = x_i * wb_i;
    assign base  = first_i ? '0 : acc_i;
    assign mac_o = base + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

    // One guard bit keeps the bias add exact before the range check.
    assign sum  = {acc_i[ACC_WIDTH-1], acc_i}
                + {{(SW-WB_WIDTH){wb_i[WB_WIDTH-1]}}, wb_i};
    assign top  = sum[SW-1:OUT_WIDTH-1];
    assign fits = (&top) | ~(|top);
    assign sat  = fits ? sum[OUT_WIDTH-1:0]
                       : (sum[SW-1] ? SMIN : SMAX);

`ifdef DENSE_RELU_EN
    assign res_o = sat[OUT_WIDTH-1] ? '0 : sat;
`else
    assign res_o = sat;
`endif

endmodule

// File: rtl/dense_mac_layer.sv
// Time-multiplexed fully connected layer with one shared MAC.
// Build option DENSE_RELU_EN enables ReLU on every stored neuron.
module dense_mac_layer
    import nn_parameters::*;
#(
    parameter int IN_SIZE    = 26,
    parameter int OUT_SIZE   = 32,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 24,
    parameter int WB_WIDTH   = 8,
    parameter int ADDR_WIDTH = $clog2(OUT_SIZE * (IN_SIZE + 1))
) (
    input logic              clk,
    input logic              rst,
    dense_mac_layer_if.slave bus
);

    localparam int ACC_WIDTH = acc_width(IN_WIDTH, WB_WIDTH, IN_SIZE);
    localparam int IW = $clog2(IN_SIZE + 1);
    localparam int JW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(OUT_SIZE * (IN_SIZE + 1) - 1);
    localparam logic [IW-1:0] BIAS_IDX = IW'(IN_SIZE);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [IW-1:0]                 i_q, i_d;
    logic [JW-1:0]                 j_q, j_d;
    logic                          vld_q;
    logic [IW-1:0]                 pi_q;
    logic [JW-1:0]                 pj_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic [IN_SIZE*IN_WIDTH-1:0]   x_q;
    logic [OUT_SIZE*OUT_WIDTH-1:0] out_q;

    logic [IW-1:0]                 x_idx;
    logic signed [IN_WIDTH-1:0]    x_sel;
    logic signed [ACC_WIDTH-1:0]   mac;
    logic signed [OUT_WIDTH-1:0]   res;

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.wb_rd_en  = (state_q == ST_RUN);
    assign bus.wb_addr   = addr_q;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = out_q;
    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        i_d     = '0;
        j_d     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                addr_d = addr_q + 1'b1;
                i_d    = (i_q == BIAS_IDX) ? '0 : i_q + 1'b1;
                j_d    = (i_q == BIAS_IDX) ? j_q + 1'b1 : j_q;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    addr_d  = '0;
                    j_d     = '0;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The bias beat reads no input element; park the select at 0.
    assign x_idx = (pi_q == BIAS_IDX) ? '0 : pi_q;
    assign x_sel = x_q[int'(x_idx)*IN_WIDTH +: IN_WIDTH];

    dense_mac_saturate #(
        .IN_WIDTH (IN_WIDTH),
        .WB_WIDTH (WB_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_mac (
        .x_i    (x_sel),
        .wb_i   ($signed(bus.wb_data)),
        .acc_i  (acc_q),
        .first_i(pi_q == '0),
        .mac_o  (mac),
        .res_o  (res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
            vld_q   <= 1'b0;
            pi_q    <= '0;
            pj_q    <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            i_q     <= i_d;
            j_q     <= j_d;
            // Read data lands one cycle after the strobe.
            vld_q   <= (state_q == ST_RUN);
            pi_q    <= i_q;
            pj_q    <= j_q;
            if (state_q == ST_IDLE && bus.in_valid) x_q <= bus.in_data;
            if (vld_q) begin
                if (pi_q == BIAS_IDX)
                    out_q[int'(pj_q)*OUT_WIDTH +: OUT_WIDTH] <= res;
                else
                    acc_q <= mac;
            end
        end
    end

endmodule

// File: tb/tb_dense_mac_layer.sv
// Directed and randomized bench for dense_mac_layer in both layer shapes.
// Expected values come from plain-arithmetic models of each neuron.
module tb_dense_mac_layer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int rd1 = 0;
    int ord1 = 0;
    int nxt1 = 0;

    longint     x1 [26];
    logic [7:0] mem1 [864];
    longint     x2 [32];
    logic [7:0] mem2 [99];
    longint     ea [32];

    dense_mac_layer_if i1 ();
    dense_mac_layer_if #(
        .IN_SIZE(32), .OUT_SIZE(3), .IN_WIDTH(24),
        .OUT_WIDTH(32), .WB_WIDTH(8)
    ) i2 ();

    dense_mac_layer u1 (.clk(clk), .rst(rst), .bus(i1));

    dense_mac_layer #(
        .IN_SIZE(32), .OUT_SIZE(3), .IN_WIDTH(24),
        .OUT_WIDTH(32), .WB_WIDTH(8)
    ) u2 (.clk(clk), .rst(rst), .bus(i2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (i1.wb_rd_en) begin
            i1.wb_data <= mem1[i1.wb_addr];
            if (int'(i1.wb_addr) != nxt1) ord1 <= ord1 + 1;
            nxt1 <= int'(i1.wb_addr) + 1;
            rd1  <= rd1 + 1;
        end else begin
            nxt1 <= 0;
        end
        if (i2.wb_rd_en) i2.wb_data <= mem2[i2.wb_addr];
    end

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint clampv(longint s, int w);
        longint hi, lo, r;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        r = s;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`ifdef DENSE_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    function automatic longint ref1(int j);
        longint s;
        s = longint'($signed(mem1[j*27+26]));
        for (int i = 0; i < 26; i++)
            s += x1[i] * longint'($signed(mem1[j*27+i]));
        return clampv(s, 24);
    endfunction

    function automatic longint ref2(int j);
        longint s;
        s = longint'($signed(mem2[j*33+32]));
        for (int i = 0; i < 32; i++)
            s += x2[i] * longint'($signed(mem2[j*33+i]));
        return clampv(s, 32);
    endfunction

    function automatic logic signed [63:0] o1(int j);
        return $signed(i1.out_data[j*24 +: 24]);
    endfunction

    function automatic logic signed [63:0] o2(int j);
        return $signed(i2.out_data[j*32 +: 32]);
    endfunction

    task automatic setx1(input bit rnd, input int xv);
        for (int i = 0; i < 26; i++)
            x1[i] = rnd ? longint'($signed(16'($urandom))) : longint'(xv);
    endtask

    task automatic setw1(input bit rnd, input int wv, input int bv);
        for (int a = 0; a < 864; a++)
            mem1[a] = rnd ? 8'($urandom) : ((a % 27 == 26) ? 8'(bv) : 8'(wv));
    endtask

    task automatic pack1();
        for (int i = 0; i < 26; i++) i1.in_data[i*16 +: 16] = 16'(x1[i]);
    endtask

    task automatic wait1(output int n);
        n = 0;
        while (i1.out_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic out_hs1(input string tag);
        i1.out_ready = 1'b1;
        @(negedge clk);
        i1.out_ready = 1'b0;
        chk({tag, "_ovld_low"}, i1.out_valid, 0);
        chk({tag, "_rdy_back"}, i1.in_ready, 1);
    endtask

    task automatic go1(input string tag, input int hold);
        int t0, n, r0, o0;
        pack1();
        @(negedge clk);
        chk({tag, "_rdy"}, i1.in_ready, 1);
        i1.in_valid = 1'b1;
        t0 = cyc;
        r0 = rd1;
        o0 = ord1;
        @(negedge clk);
        i1.in_valid = 1'b0;
        chk({tag, "_busy"}, i1.busy, 1);
        wait1(n);
        chk({tag, "_lat"}, cyc - t0, 866);
        chk({tag, "_reads"}, rd1 - r0, 864);
        chk({tag, "_order"}, ord1 - o0, 0);
        for (int j = 0; j < 32; j++)
            chk($sformatf("%s_y%0d", tag, j), o1(j), ref1(j));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk($sformatf("%s_hold%0d_vld", tag, k), i1.out_valid, 1);
            chk($sformatf("%s_hold%0d_rdy", tag, k), i1.in_ready, 0);
            for (int j = 0; j < 32; j++)
                chk($sformatf("%s_hold%0d_y%0d", tag, k, j), o1(j), ref1(j));
        end
        out_hs1(tag);
    endtask

    task automatic go2(input string tag);
        int t0, n;
        for (int i = 0; i < 32; i++) i2.in_data[i*24 +: 24] = 24'(x2[i]);
        @(negedge clk);
        chk({tag, "_rdy"}, i2.in_ready, 1);
        i2.in_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        i2.in_valid = 1'b0;
        n = 0;
        while (i2.out_valid !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, cyc - t0, 101);
        for (int j = 0; j < 3; j++)
            chk($sformatf("%s_y%0d", tag, j), o2(j), ref2(j));
        i2.out_ready = 1'b1;
        @(negedge clk);
        i2.out_ready = 1'b0;
        chk({tag, "_rdy_back"}, i2.in_ready, 1);
    endtask

    initial begin
        int t0, n;
        i1.in_valid  = 1'b0;
        i1.in_data   = '0;
        i1.out_ready = 1'b0;
        i2.in_valid  = 1'b0;
        i2.in_data   = '0;
        i2.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_in_ready", i1.in_ready, 1);
        chk("reset_out_valid", i1.out_valid, 0);
        chk("reset_busy", i1.busy, 0);
        chk("reset_rd_en", i1.wb_rd_en, 0);
        chk("reset_addr", i1.wb_addr, 0);
        chk("reset_out_zero", i1.out_data === '0, 1);
        chk("reset2_in_ready", i2.in_ready, 1);
        chk("reset2_out_zero", i2.out_data === '0, 1);
        rst = 1'b0;

        setx1(0, 1);
        setw1(0, 1, 0);
        go1("ones", 0);
        chk("ones_y0_const", o1(0), 26);

        setx1(0, 32767);
        setw1(0, 127, 127);
        go1("satpos", 0);

        setw1(0, -128, -128);
        go1("satneg", 0);

        setx1(1, 0);
        setw1(1, 0, 0);
        go1("rand_hold", 20);

        setx1(1, 0);
        go1("rand", 0);

        // Abort a run 400 cycles in, then run a fresh vector.
        setx1(1, 0);
        setw1(1, 0, 0);
        pack1();
        @(negedge clk);
        i1.in_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        i1.in_valid = 1'b0;
        while (cyc - t0 < 400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", i1.in_ready, 1);
        chk("abort_out_valid", i1.out_valid, 0);
        chk("abort_rd_en", i1.wb_rd_en, 0);
        chk("abort_busy", i1.busy, 0);
        chk("abort_addr", i1.wb_addr, 0);
        setx1(1, 0);
        go1("abort_fresh", 0);

        // Back-to-back with in_valid held high; B sits on the bus during A.
        setx1(1, 0);
        pack1();
        @(negedge clk);
        i1.in_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        for (int j = 0; j < 32; j++) ea[j] = ref1(j);
        setx1(1, 0);
        pack1();
        wait1(n);
        chk("b2b_a_lat", cyc - t0, 866);
        for (int j = 0; j < 32; j++)
            chk($sformatf("b2b_a_y%0d", j), o1(j), ea[j]);
        chk("b2b_rdy_at_hs", i1.in_ready, 0);
        i1.out_ready = 1'b1;
        @(negedge clk);
        i1.out_ready = 1'b0;
        chk("b2b_rdy_after_hs", i1.in_ready, 1);
        chk("b2b_idle_busy", i1.busy, 0);
        t0 = cyc;
        @(negedge clk);
        i1.in_valid = 1'b0;
        chk("b2b_b_busy", i1.busy, 1);
        wait1(n);
        chk("b2b_b_lat", cyc - t0, 866);
        for (int j = 0; j < 32; j++)
            chk($sformatf("b2b_b_y%0d", j), o1(j), ref1(j));
        out_hs1("b2b_b");

        // Dense 2 shape.
        for (int i = 0; i < 32; i++) x2[i] = longint'(i);
        for (int a = 0; a < 99; a++)
            mem2[a] = (a % 33 == 32) ? 8'(-10) : 8'(a / 33 + 1);
        go2("d2_dir");
        chk("d2_dir_y0_const", o2(0), 486);
        chk("d2_dir_y2_const", o2(2), 1478);
        for (int a = 0; a < 32; a++) mem2[a] = 8'hFF;
        go2("d2_neg");
`ifdef DENSE_RELU_EN
        chk("d2_neg_y0_const", o2(0), 0);
`else
        chk("d2_neg_y0_const", o2(0), -506);
`endif
        for (int i = 0; i < 32; i++) x2[i] = longint'($signed(24'($urandom)));
        for (int a = 0; a < 99; a++) mem2[a] = 8'($urandom);
        go2("d2_rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
